spi_max7219_receiver: RTL and testbench
=======================================

# spi_max7219_receiver

Receive-side model of the MAX7219 daisy chain: samples the three-wire SPI bus (Stb/Clk/Din) produced by the MAX7219 driver, deserializes one full chain-wide transfer per strobe, and decodes it into a per-device register shadow and a pixel frame. It sits on the board or in the bench as the far end of the display link. It provides loopback self-check of the pattern generators and a readable copy of what the physical display shows.

## Interface
- DISP_COLUMNS, 4, 8x8 matrices per display row
- DISP_ROWS, 5, matrix rows; chain length N = DISP_ROWS*DISP_COLUMNS
- DATA_WIDTH, N*16, bits per complete chain transfer (derived, not overridden)
- i_Clk  in  1  system clock (12 MHz)
- i_Rst_n  in  1  reset; asynchronous, active-low
- i_SPI_MAX7219_Stb  in  1  LOAD/CS from driver, asynchronous to i_Clk
- i_SPI_MAX7219_Clk  in  1  SPI clock, asynchronous to i_Clk
- i_SPI_MAX7219_Din  in  1  SPI data, asynchronous to i_Clk
- o_Frame  out  [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0]  digit registers 1..8 per device; same layout as the driver's data stream minus address bytes
- o_Intensity  out  [N-1:0][3:0]  register 0xA per device
- o_ScanLimit  out  [N-1:0][2:0]  register 0xB per device
- o_Shutdown_n  out  [N-1:0]  register 0xC bit 0 (0 = shutdown)
- o_DecodeMode  out  [N-1:0][7:0]  register 0x9
- o_DisplayTest  out  [N-1:0]  register 0xF bit 0
- o_Commit  out  1  one-cycle pulse when a transfer is latched
- o_Err  out  1  one-cycle pulse when a transfer is rejected

## Operation
- All three inputs pass through 2-FF synchronizers; Stb and Clk get 1-cycle edge detectors on the synchronized value.
- Stb falling edge: clear bit counter and overflow flag; start of transfer.
- Clk rising edge while synchronized Stb = 0: shift synchronized Din into a DATA_WIDTH shift register at the LSB, MSB first. Increment the bit counter, saturating at DATA_WIDTH; a shift at saturation sets the overflow flag.
- Clk edges while Stb = 1 are ignored.
- Stb rising edge (latch) with count == DATA_WIDTH and no overflow: commit. Word k = shift[16k+15:16k] targets device k; device 0 is the first in chain and the last word shifted.
  - Per word, addr = bits[11:8], data = bits[7:0].
  - addr 0x1–0x8 writes digit row addr-1.
  - 0x9, 0xA, 0xB, 0xC and 0xF write their registers.
  - 0x0 (no-op) and 0xD/0xE leave the device unchanged.
- Any other latch condition (short or overflowed count): no register change; pulse o_Err.
- Device k maps to o_Frame[row][k / DISP_COLUMNS][k % DISP_COLUMNS].
- Reset values: o_Frame 0, o_Intensity 0, o_ScanLimit 0, o_Shutdown_n 0, o_DecodeMode 0, o_DisplayTest 0, o_Commit 0, o_Err 0, counter 0, shift register 0.
- Reset mid-transfer discards partial data. The next transfer needs a fresh Stb falling edge.

## Timing
- Input edge to detected edge: 3 i_Clk cycles (2 sync + 1 detect).
- Stb pin rise to o_Commit/o_Err pulse, and to register update in the same cycle: 4 i_Clk cycles.
- Minimum SPI Clk high and low time, and Stb high time: 2 i_Clk cycles. The driver setting of 10 meets this.
- Din must be stable for 2 i_Clk cycles around the Clk rising edge; Din is sampled on the same synchronized cycle the edge is detected.
- Simultaneous Clk rise and Stb rise detected in the same cycle: Stb wins and the bit is not shifted.
- o_Frame holds between commits and never shows a partial transfer.

## Configuration
- SPI_MAX7219_RX_STATS_EN defined: adds output o_CommitCount [15:0] and output o_ErrCount [15:0].
  - Both counters reset to 0.
  - Each increments on its pulse and wraps 0xFFFF -> 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Package max7219_pkg holds:
  - register address localparams (NOOP, DIGIT0..7, DECODE, INTENSITY, SCANLIMIT, SHUTDOWN, TEST);
  - typedef for the 16-bit word with addr/data fields;
  - the 8x8 row typedef, shared with the driver.
- Sub-module spi_input_sync: 2-FF synchronizer plus rise/fall pulse outputs, instantiated three times (Din uses level only).

## Test plan
- After reset: all outputs at reset values; Shutdown_n = 0.
- One transfer of 20 words {0x0C,0x01}, then Stb rises: o_Commit pulses 4 cycles later; o_Shutdown_n = all ones; o_Err stays 0.
- Transfer with word for device 0 = 0x03A5 and all others 0x0000: o_Frame[2][0][0] = 0xA5; all other rows unchanged.
- 319 bits then Stb rise: o_Err pulses; outputs unchanged.
- 321 bits then Stb rise: o_Err pulses; outputs unchanged.
- i_Rst_n asserted after 100 bits, released, then a full valid transfer: commits correctly, no o_Err.
- With SPI_MAX7219_RX_STATS_EN: 3 good transfers and 2 bad ones give o_CommitCount = 3 and o_ErrCount = 2.

Source files
------------

// File: rtl/max7219_pkg.sv
// max7219_pkg
//   Shared definitions for the MAX7219 display link: register addresses,
//   the 16-bit serial word layout and the 8x8 matrix row types. The driver
//   side uses the same row typedefs, so frame data lines up on both ends.
//   No ports.
package max7219_pkg;

  // MAX7219 register addresses (bits [11:8] of a serial word).
  localparam logic [3:0] NOOP      = 4'h0;
  localparam logic [3:0] DIGIT0    = 4'h1;
  localparam logic [3:0] DIGIT1    = 4'h2;
  localparam logic [3:0] DIGIT2    = 4'h3;
  localparam logic [3:0] DIGIT3    = 4'h4;
  localparam logic [3:0] DIGIT4    = 4'h5;
  localparam logic [3:0] DIGIT5    = 4'h6;
  localparam logic [3:0] DIGIT6    = 4'h7;
  localparam logic [3:0] DIGIT7    = 4'h8;
  localparam logic [3:0] DECODE    = 4'h9;
  localparam logic [3:0] INTENSITY = 4'hA;
  localparam logic [3:0] SCANLIMIT = 4'hB;
  localparam logic [3:0] SHUTDOWN  = 4'hC;
  localparam logic [3:0] TEST      = 4'hF;

  localparam int WORD_BITS = 16;

  // One serial word as it appears on the wire, MSB first. The top nibble
  // is don't-care on the MAX7219.
  typedef struct packed {
    logic [3:0] pad;
    logic [3:0] addr;
    logic [7:0] data;
  } max7219_word_t;

  // One 8-pixel row of an 8x8 matrix, and a full matrix of 8 rows.
  typedef logic [7:0] max7219_row_t;
  typedef max7219_row_t [7:0] max7219_matrix_t;

  // Digit register address 0x1..0x8 -> row index 0..7.
  function automatic logic [2:0] digit_row(input logic [3:0] addr);
    return 3'(addr - 4'd1);
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync
//   Two-flop synchronizer for one asynchronous input, followed by a
//   registered edge detector.
//   Ports:
//     i_Clk, i_Rst_n : system clock, async active-low reset
//     i_Async        : asynchronous input pin
//     o_Level        : synchronized level, delayed one cycle so it is aligned
//                      with o_Rise/o_Fall (same cycle the edge is reported)
//     o_Rise, o_Fall : one-cycle pulses on synchronized rising/falling edges
//   RESET_VAL sets the assumed idle level so that an input sitting at its
//   idle value when reset releases does not produce a spurious edge.
module spi_input_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Async,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta   <= RESET_VAL;
      sync   <= RESET_VAL;
      prev   <= RESET_VAL;
      o_Rise <= 1'b0;
      o_Fall <= 1'b0;
    end else begin
      meta   <= i_Async;
      sync   <= meta;
      prev   <= sync;
      o_Rise <= sync & ~prev;
      o_Fall <= ~sync & prev;
    end
  end

  assign o_Level = prev;

endmodule

// File: rtl/spi_max7219_receiver.sv
// spi_max7219_receiver
//   Far end of the MAX7219 daisy-chain link. Samples the Stb/Clk/Din bus,
//   deserializes one full chain transfer per Stb low period and, on Stb
//   rising, decodes it into per-device register shadows and a pixel frame.
//   Ports:
//     i_Clk, i_Rst_n        : system clock, async active-low reset
//     i_SPI_MAX7219_Stb/Clk/Din : SPI bus from the driver (async to i_Clk)
//     o_Frame               : digit rows [row][matrix row][matrix col][8 px]
//     o_Intensity, o_ScanLimit, o_Shutdown_n, o_DecodeMode, o_DisplayTest :
//                             per-device register shadows
//     o_Commit / o_Err      : one-cycle pulse per accepted / rejected latch
//   Optional feature macro SPI_MAX7219_RX_STATS_EN adds o_CommitCount and
//   o_ErrCount, 16-bit wrapping counters of the two pulses.
module spi_max7219_receiver
  import max7219_pkg::*;
#(
  parameter int DISP_COLUMNS = 4,
  parameter int DISP_ROWS    = 5
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_SPI_MAX7219_Stb,
  input  logic i_SPI_MAX7219_Clk,
  input  logic i_SPI_MAX7219_Din,
  output logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0] o_Frame,
  output logic [DISP_ROWS*DISP_COLUMNS-1:0][3:0] o_Intensity,
  output logic [DISP_ROWS*DISP_COLUMNS-1:0][2:0] o_ScanLimit,
  output logic [DISP_ROWS*DISP_COLUMNS-1:0]      o_Shutdown_n,
  output logic [DISP_ROWS*DISP_COLUMNS-1:0][7:0] o_DecodeMode,
  output logic [DISP_ROWS*DISP_COLUMNS-1:0]      o_DisplayTest,
  output logic o_Commit,
  output logic o_Err
`ifdef SPI_MAX7219_RX_STATS_EN
  ,
  output logic [15:0] o_CommitCount,
  output logic [15:0] o_ErrCount
`endif
);

  localparam int N          = DISP_ROWS * DISP_COLUMNS;
  localparam int DATA_WIDTH = N * WORD_BITS;
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  logic stb_level, stb_rise, stb_fall;
  logic clk_rise;
  logic din_level;
  logic clk_level_unused, clk_fall_unused;
  logic din_rise_unused, din_fall_unused;

  // Stb idles high, so its synchronizer resets to 1.
  spi_input_sync #(.RESET_VAL(1'b1)) u_stb_sync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Async (i_SPI_MAX7219_Stb),
    .o_Level (stb_level),
    .o_Rise  (stb_rise),
    .o_Fall  (stb_fall)
  );

  spi_input_sync #(.RESET_VAL(1'b0)) u_clk_sync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Async (i_SPI_MAX7219_Clk),
    .o_Level (clk_level_unused),
    .o_Rise  (clk_rise),
    .o_Fall  (clk_fall_unused)
  );

  spi_input_sync #(.RESET_VAL(1'b0)) u_din_sync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Async (i_SPI_MAX7219_Din),
    .o_Level (din_level),
    .o_Rise  (din_rise_unused),
    .o_Fall  (din_fall_unused)
  );

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  ovf;
  logic                  latch_ok;

  assign latch_ok = stb_rise && (bit_cnt == CNT_FULL) && !ovf;

  // Shift/count path. stb_level is already high in the cycle stb_rise is
  // reported, so a Clk edge detected together with the latch is dropped.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      ovf      <= 1'b0;
      o_Commit <= 1'b0;
      o_Err    <= 1'b0;
    end else begin
      o_Commit <= 1'b0;
      o_Err    <= 1'b0;
      if (stb_fall) begin
        bit_cnt <= '0;
        ovf     <= 1'b0;
      end else if (clk_rise && !stb_level) begin
        shift_q <= {shift_q[DATA_WIDTH-2:0], din_level};
        if (bit_cnt == CNT_FULL) begin
          ovf <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (stb_rise) begin
        if (latch_ok) begin
          o_Commit <= 1'b1;
        end else begin
          o_Err <= 1'b1;
        end
      end
    end
  end

  // Per-device register shadows. Device k owns shift_q word k; device 0 is
  // first in the chain, i.e. the last word shifted in.
  for (genvar k = 0; k < N; k++) begin : g_dev
    max7219_word_t word;
    max7219_row_t [0:7] rows;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n;
    logic [7:0] decode_mode;
    logic       display_test;
    logic       pad_unused;

    assign word       = shift_q[WORD_BITS*k +: WORD_BITS];
    assign pad_unused = ^word.pad;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
        rows         <= '0;
        intensity    <= '0;
        scan_limit   <= '0;
        shutdown_n   <= 1'b0;
        decode_mode  <= '0;
        display_test <= 1'b0;
      end else if (latch_ok) begin
        case (word.addr)
          DIGIT0, DIGIT1, DIGIT2, DIGIT3,
          DIGIT4, DIGIT5, DIGIT6, DIGIT7: rows[digit_row(word.addr)] <= word.data;
          DECODE:    decode_mode  <= word.data;
          INTENSITY: intensity    <= word.data[3:0];
          SCANLIMIT: scan_limit   <= word.data[2:0];
          SHUTDOWN:  shutdown_n   <= word.data[0];
          TEST:      display_test <= word.data[0];
          NOOP:      ;
          default:   ;  // 0xD, 0xE leave the device untouched
        endcase
      end
    end

    for (genvar r = 0; r < 8; r++) begin : g_row
      assign o_Frame[r][k / DISP_COLUMNS][k % DISP_COLUMNS] = rows[r];
    end

    assign o_Intensity[k]   = intensity;
    assign o_ScanLimit[k]   = scan_limit;
    assign o_Shutdown_n[k]  = shutdown_n;
    assign o_DecodeMode[k]  = decode_mode;
    assign o_DisplayTest[k] = display_test;
  end

`ifdef SPI_MAX7219_RX_STATS_EN
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_CommitCount <= '0;
      o_ErrCount    <= '0;
    end else begin
      if (o_Commit) o_CommitCount <= o_CommitCount + 16'd1;
      if (o_Err)    o_ErrCount    <= o_ErrCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_max7219_receiver.sv
module tb_spi_max7219_receiver;

  localparam int DISP_COLUMNS = 4;
  localparam int DISP_ROWS    = 5;
  localparam int N            = DISP_COLUMNS * DISP_ROWS;
  localparam int DW           = N * 16;
  localparam int H            = 3;  // SPI half period in i_Clk cycles

  // ---------------- clock / reset ----------------
  logic i_Clk   = 1'b0;
  logic i_Rst_n = 1'b0;
  logic stb     = 1'b1;
  logic sclk    = 1'b0;
  logic din     = 1'b0;

  always #5 i_Clk = ~i_Clk;

  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0] frame;
  logic [N-1:0][3:0] intensity;
  logic [N-1:0][2:0] scan_limit;
  logic [N-1:0]      shutdown_n;
  logic [N-1:0][7:0] decode_mode;
  logic [N-1:0]      display_test;
  logic              commit;
  logic              err;
`ifdef SPI_MAX7219_RX_STATS_EN
  logic [15:0] commit_count;
  logic [15:0] err_count;
`endif

  spi_max7219_receiver #(
    .DISP_COLUMNS (DISP_COLUMNS),
    .DISP_ROWS    (DISP_ROWS)
  ) dut (
    .i_Clk             (i_Clk),
    .i_Rst_n           (i_Rst_n),
    .i_SPI_MAX7219_Stb (stb),
    .i_SPI_MAX7219_Clk (sclk),
    .i_SPI_MAX7219_Din (din),
    .o_Frame           (frame),
    .o_Intensity       (intensity),
    .o_ScanLimit       (scan_limit),
    .o_Shutdown_n      (shutdown_n),
    .o_DecodeMode      (decode_mode),
    .o_DisplayTest     (display_test),
    .o_Commit          (commit),
    .o_Err             (err)
`ifdef SPI_MAX7219_RX_STATS_EN
    ,
    .o_CommitCount     (commit_count),
    .o_ErrCount        (err_count)
`endif
  );

  // ---------------- reference model ----------------
  logic [7:0] m_row  [8][N];
  logic [3:0] m_int  [N];
  logic [2:0] m_scan [N];
  logic       m_shdn [N];
  logic [7:0] m_dec  [N];
  logic       m_test [N];
  int         n_commit;
  int         n_err;

  logic [15:0] tx_words[$];  // in shift order: first entry goes to the last device
  logic        tx_bits[$];

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      for (int r = 0; r < 8; r++) m_row[r][k] = 8'h00;
      m_int[k]  = 4'h0;
      m_scan[k] = 3'h0;
      m_shdn[k] = 1'b0;
      m_dec[k]  = 8'h00;
      m_test[k] = 1'b0;
    end
    n_commit = 0;
    n_err    = 0;
  endtask

  task automatic model_commit();
    logic [15:0] w;
    int a;
    for (int k = 0; k < N; k++) begin
      w = tx_words[N-1-k];
      a = int'(w[11:8]);
      if (a >= 1 && a <= 8) m_row[a-1][k] = w[7:0];
      else if (a == 9)  m_dec[k]  = w[7:0];
      else if (a == 10) m_int[k]  = w[3:0];
      else if (a == 11) m_scan[k] = w[2:0];
      else if (a == 12) m_shdn[k] = w[0];
      else if (a == 15) m_test[k] = w[0];
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];  // {err, commit} expected at each latch
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0] e_row;
    logic [N-1:0][3:0] e_int;
    logic [N-1:0][2:0] e_scan;
    logic [N-1:0]      e_shdn;
    logic [N-1:0][7:0] e_dec;
    logic [N-1:0]      e_test;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) e_row[k / DISP_COLUMNS][k % DISP_COLUMNS] = m_row[r][k];
      check($sformatf("frame_row%0d", r), 160'(frame[r]), 160'(e_row));
    end
    for (int k = 0; k < N; k++) begin
      e_int[k]  = m_int[k];
      e_scan[k] = m_scan[k];
      e_shdn[k] = m_shdn[k];
      e_dec[k]  = m_dec[k];
      e_test[k] = m_test[k];
    end
    check("intensity",    160'(intensity),    160'(e_int));
    check("scan_limit",   160'(scan_limit),   160'(e_scan));
    check("shutdown_n",   160'(shutdown_n),   160'(e_shdn));
    check("decode_mode",  160'(decode_mode),  160'(e_dec));
    check("display_test", 160'(display_test), 160'(e_test));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic random_words();
    tx_words.delete();
    for (int j = 0; j < N; j++) tx_words.push_back(16'($urandom_range(0, 65535)));
  endtask

  task automatic words_to_bits();
    tx_bits.delete();
    foreach (tx_words[j]) for (int b = 15; b >= 0; b--) tx_bits.push_back(tx_words[j][b]);
  endtask

  task automatic spi_shift(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      din = (i < tx_bits.size()) ? tx_bits[i] : 1'($urandom_range(0, 1));
      wait_clks(H);
      sclk = 1'b1;
      wait_clks(H);
      sclk = 1'b0;
    end
  endtask

  // Raise Stb (optionally together with one more Clk rise) and check the
  // pulse lands exactly 4 cycles after the pin edge, one cycle wide.
  task automatic spi_latch(input logic simul);
    logic [1:0] exp;
    if (simul) begin
      din = 1'($urandom_range(0, 1));
      wait_clks(H);
      sclk = 1'b1;
    end
    stb = 1'b1;
    wait_clks(3);
    check("pulse_early", 160'({err, commit}), 160'(2'b00));
    wait_clks(1);
    exp = exp_q.pop_front();
    check("pulse", 160'({err, commit}), 160'(exp));
    check_outputs();
    wait_clks(1);
    check("pulse_width", 160'({err, commit}), 160'(2'b00));
    sclk = 1'b0;
    wait_clks(H);
  endtask

  task automatic run_transfer(input int nbits, input logic simul);
    words_to_bits();
    stb = 1'b0;
    wait_clks(H);
    spi_shift(nbits);
    if (nbits == DW) begin
      exp_q.push_back(2'b01);
      model_commit();
      n_commit++;
    end else begin
      exp_q.push_back(2'b10);
      n_err++;
    end
    wait_clks(H);
    spi_latch(simul);
  endtask

  // Clock activity while Stb is high must be ignored.
  task automatic noise_clks();
    for (int i = 0; i < 6; i++) begin
      din = 1'($urandom_range(0, 1));
      wait_clks(H);
      sclk = 1'b1;
      wait_clks(H);
      sclk = 1'b0;
    end
    wait_clks(6);
    check("noise_pulse", 160'({err, commit}), 160'(2'b00));
    check_outputs();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    wait_clks(4);
    check_outputs();
    check("reset_pulse", 160'({err, commit}), 160'(2'b00));
    i_Rst_n = 1'b1;
    wait_clks(6);
    check_outputs();
    check("idle_pulse", 160'({err, commit}), 160'(2'b00));

    // Every device: shutdown register = 1.
    tx_words.delete();
    for (int j = 0; j < N; j++) tx_words.push_back(16'h0C01);
    run_transfer(DW, 1'b0);

    // Device 0 digit row 2 = 0xA5, every other device no-op.
    tx_words.delete();
    for (int j = 0; j < N; j++) tx_words.push_back(16'h0000);
    tx_words[N-1] = 16'h03A5;
    run_transfer(DW, 1'b0);

    // Short and long transfers are rejected.
    random_words();
    run_transfer(DW - 1, 1'b0);
    random_words();
    run_transfer(DW + 1, 1'b0);

    noise_clks();

    for (int t = 0; t < 5; t++) begin
      random_words();
      run_transfer(DW, 1'b0);
    end

    // Clk rise coinciding with the latch edge is not shifted.
    random_words();
    run_transfer(DW - 1, 1'b1);
    random_words();
    run_transfer(DW, 1'b1);

    // Reset in the middle of a transfer discards it.
    random_words();
    words_to_bits();
    stb = 1'b0;
    wait_clks(H);
    spi_shift(100);
    i_Rst_n = 1'b0;
    stb     = 1'b1;
    sclk    = 1'b0;
    wait_clks(2);
    model_reset();
    check_outputs();
    i_Rst_n = 1'b1;
    wait_clks(6);
    check("post_reset_pulse", 160'({err, commit}), 160'(2'b00));
    check_outputs();

    for (int t = 0; t < 2; t++) begin
      random_words();
      run_transfer(DW, 1'b0);
    end
    random_words();
    run_transfer(DW - 1, 1'b0);

`ifdef SPI_MAX7219_RX_STATS_EN
    wait_clks(3);
    check("commit_count", 160'(commit_count), 160'(n_commit));
    check("err_count",    160'(err_count),    160'(n_err));
`endif

    check("exp_q_drained", 160'(exp_q.size()), 160'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
